// File: rtl/hal_nmr_pkg.sv
// hal_nmr_pkg
// Shared definitions for the non-mergeable register bank:
//   - attribute strings that keep synthesis from merging, removing or
//     retiming a register, one set per vendor
//   - nmr_init_slice(): extracts one slot's init value from the packed INIT_VAL
//   - nmr_params_ok(): elaboration-time sanity check on WIDTH/DEPTH
package hal_nmr_pkg;

  // Upper bound on DEPTH*WIDTH so that INIT_VAL fits a fixed-width helper.
  localparam int unsigned NMR_MAX_BITS = 4096;

  // Xilinx (Vivado)
  localparam string NMR_ATTR_XLNX_KEEP       = "keep = \"true\"";
  localparam string NMR_ATTR_XLNX_DONT_TOUCH = "dont_touch = \"true\"";
  localparam string NMR_ATTR_XLNX_NO_SRL     = "shreg_extract = \"no\"";
  // Intel (Quartus)
  localparam string NMR_ATTR_ALTR_PRESERVE   = "preserve";
  localparam string NMR_ATTR_ALTR_DONT_MERGE = "dont_merge";
  // Synopsys / Microchip (Synplify)
  localparam string NMR_ATTR_SYN_PRESERVE    = "syn_preserve = 1";
  localparam string NMR_ATTR_SYN_NO_RETIME   = "syn_allow_retiming = 0";

  // Returns slot idx's init value right-aligned in a NMR_MAX_BITS vector;
  // callers take the low WIDTH bits.
  function automatic logic [NMR_MAX_BITS-1:0] nmr_init_slice(
    input logic [NMR_MAX_BITS-1:0] init,
    input int unsigned             idx,
    input int unsigned             width
  );
    logic [NMR_MAX_BITS-1:0] mask;
    mask = ~({NMR_MAX_BITS{1'b1}} << width);
    return (init >> (idx * width)) & mask;
  endfunction

  function automatic bit nmr_params_ok(input int width, input int depth);
    return (width >= 1) && (depth >= 1) && (width * depth <= NMR_MAX_BITS);
  endfunction

endpackage

// File: rtl/hal_nmr_slot.sv
// hal_nmr_slot
// One WIDTH-bit register that synthesis is told to keep as a distinct flop
// group: no merging with equivalent registers, no removal, no retiming.
// The register powers up at INIT_VAL, resets asynchronously to INIT_VAL and,
// when HAL_NMR_CLEAR_EN is defined, also clears synchronously to INIT_VAL.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   clr      synchronous active-high clear (only with HAL_NMR_CLEAR_EN)
//   data_in  next value
//   data_out registered value (straight from the flops)
module hal_nmr_slot
  import hal_nmr_pkg::*;
#(
  parameter int unsigned           WIDTH    = 1,
  parameter logic [WIDTH-1:0]      INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
`ifdef HAL_NMR_CLEAR_EN
  input  logic             clr,
`endif
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  // Attribute names are literal here because vendors parse them textually;
  // they mirror the NMR_ATTR_* strings in the package.
  (* keep = "true", dont_touch = "true", shreg_extract = "no", preserve, dont_merge, syn_preserve = 1, syn_allow_retiming = 0 *)
  logic [WIDTH-1:0] slot_reg = INIT_VAL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_reg <= INIT_VAL;
`ifdef HAL_NMR_CLEAR_EN
    end else if (clr) begin
      slot_reg <= INIT_VAL;
`endif
    end else begin
      slot_reg <= data_in;
    end
  end

  assign data_out = slot_reg;

endmodule

// File: rtl/hal_non_mergeable_registers.sv
// hal_non_mergeable_registers
// Bank of DEPTH independent WIDTH-bit registers, each kept as its own flop
// group so duplicated reset/fan-out copies stay physically separate.
// Slots never feed each other; chains are built by the caller.
// Compile-time option: HAL_NMR_CLEAR_EN adds the clr port (sync clear to
// INIT_VAL). Without it the bank loads data_in every edge while rst is low.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset, loads INIT_VAL
//   clr      synchronous active-high clear (only with HAL_NMR_CLEAR_EN)
//   data_in  [DEPTH-1:0][WIDTH-1:0] next value per slot
//   data_out [DEPTH-1:0][WIDTH-1:0] registered value per slot
// Slot i powers up / resets to INIT_VAL[i*WIDTH +: WIDTH].
module hal_non_mergeable_registers
  import hal_nmr_pkg::*;
#(
  parameter int unsigned                WIDTH    = 1,
  parameter int unsigned                DEPTH    = 1,
  parameter logic [DEPTH*WIDTH-1:0]     INIT_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef HAL_NMR_CLEAR_EN
  input  logic                         clr,
`endif
  input  logic [DEPTH-1:0][WIDTH-1:0]  data_in,
  output logic [DEPTH-1:0][WIDTH-1:0]  data_out
);

  if (!nmr_params_ok(WIDTH, DEPTH)) begin : g_bad_params
    $error("hal_non_mergeable_registers: WIDTH and DEPTH must be >= 1 and WIDTH*DEPTH <= NMR_MAX_BITS");
  end

  localparam logic [NMR_MAX_BITS-1:0] INIT_EXT = NMR_MAX_BITS'(INIT_VAL);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    localparam logic [NMR_MAX_BITS-1:0] SLICE = nmr_init_slice(INIT_EXT, gi, WIDTH);

    hal_nmr_slot #(
      .WIDTH    (WIDTH),
      .INIT_VAL (SLICE[WIDTH-1:0])
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
`ifdef HAL_NMR_CLEAR_EN
      .clr      (clr),
`endif
      .data_in  (data_in[gi]),
      .data_out (data_out[gi])
    );
  end

endmodule

// File: tb/tb_hal_non_mergeable_registers.sv
// Directed bench for hal_non_mergeable_registers: a WIDTH=2/DEPTH=3 bank with
// INIT_VAL=6'b101101 and a WIDTH=1/DEPTH=4 bank fed identical bits.
module tb_hal_non_mergeable_registers;

  logic             clk;
  logic             rst;
  logic             clr;
  logic [2:0][1:0]  din;
  logic [2:0][1:0]  dout;
  logic [3:0]       dup_in;
  logic [3:0]       dup_out;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] INIT6 = 6'b101101;

  hal_non_mergeable_registers #(
    .WIDTH    (2),
    .DEPTH    (3),
    .INIT_VAL (INIT6)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
`ifdef HAL_NMR_CLEAR_EN
    .clr      (clr),
`endif
    .data_in  (din),
    .data_out (dout)
  );

  hal_non_mergeable_registers #(
    .WIDTH    (1),
    .DEPTH    (4),
    .INIT_VAL (4'b0000)
  ) u_dup (
    .clk      (clk),
    .rst      (rst),
`ifdef HAL_NMR_CLEAR_EN
    .clr      (clr),
`endif
    .data_in  (dup_in),
    .data_out (dup_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s val=%0h t=%0t", tag, obs, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b0;
    clr    = 1'b0;
    din    = '0;
    dup_in = '0;

    // Power-on value before any edge or reset.
    #2;
    check_value("poweron", 32'(dout), 32'(INIT6));
    check_value("poweron_slot0", 32'(dout[0]), 32'd1);
    check_value("poweron_slot2", 32'(dout[2]), 32'd2);
    check_value("dup_poweron", 32'(dup_out), 32'h0);

    // One-cycle latency.
    din    = {2'b00, 2'b01, 2'b10};
    dup_in = 4'b1111;
    tick();
    check_value("load1", 32'(dout), 32'h06);
    check_value("dup_ones", 32'(dup_out), 32'hf);
    din    = 6'b111001;
    dup_in = 4'b0000;
    #3;
    check_value("no_early_update", 32'(dout), 32'h06);
    tick();
    check_value("load2", 32'(dout), 32'h39);
    check_value("dup_zeros", 32'(dup_out), 32'h0);

    // Async reset between edges, held across an edge, then released.
    din = 6'b010101;
    #2;
    rst = 1'b1;
    #1;
    check_value("rst_async", 32'(dout), 32'(INIT6));
    tick();
    check_value("rst_held", 32'(dout), 32'(INIT6));
    #2;
    rst = 1'b0;
    #1;
    check_value("rst_release_hold", 32'(dout), 32'(INIT6));
    tick();
    check_value("first_capture", 32'(dout), 32'h15);

`ifdef HAL_NMR_CLEAR_EN
    // One-cycle clear with all-ones data.
    din = 6'b111111;
    clr = 1'b1;
    tick();
    check_value("clr_pulse", 32'(dout), 32'(INIT6));
    clr = 1'b0;
    tick();
    check_value("clr_resume", 32'(dout), 32'h3f);
    // Held clear.
    clr = 1'b1;
    tick();
    check_value("clr_held1", 32'(dout), 32'(INIT6));
    tick();
    check_value("clr_held2", 32'(dout), 32'(INIT6));
    clr = 1'b0;
    tick();
    check_value("clr_release", 32'(dout), 32'h3f);
    // rst and clr together: reset acts immediately.
    #2;
    rst = 1'b1;
    clr = 1'b1;
    #1;
    check_value("rst_over_clr", 32'(dout), 32'(INIT6));
    #2;
    rst = 1'b0;
    clr = 1'b0;
    din = 6'b100110;
    tick();
    check_value("after_rst_clr", 32'(dout), 32'h26);
`else
    // No clear: bank follows data_in on every edge.
    din = 6'b100110;
    tick();
    check_value("follow_a", 32'(dout), 32'h26);
    din = 6'b011011;
    tick();
    check_value("follow_b", 32'(dout), 32'h1b);
`endif

    // Identical data on every slot of the duplicated bank.
    dup_in = 4'b1111;
    tick();
    check_value("dup_final", 32'(dup_out), 32'hf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
